// File: rtl/scrambler_pkg.sv
// Shared scrambler definitions: FSM state encoding, frame constants, seed helpers.
package scrambler_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SEED    = 3'd1;
  localparam state_t ST_SERVICE = 3'd2;
  localparam state_t ST_PAYLOAD = 3'd3;
  localparam state_t ST_TAIL    = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  localparam int SERVICE_BITS = 16;
  localparam int SCR_W        = 7;
  localparam logic [SCR_W-1:0] DEFAULT_SEED = 7'h7F;

  // An all-zero seed would lock the scrambler, so it is replaced.
  function automatic logic [SCR_W-1:0] fix_seed(input logic [SCR_W-1:0] s);
    return (s == '0) ? DEFAULT_SEED : s;
  endfunction

  function automatic logic [SCR_W-1:0] next_rot_seed(input logic [SCR_W-1:0] s);
    return (s == DEFAULT_SEED) ? 7'h01 : s + 7'd1;
  endfunction

endpackage

// File: rtl/scrambler_frame_ctrl_if.sv
// Frame request, payload byte handshake and scrambler drive signals of the frame controller.
interface scrambler_frame_ctrl_if #(parameter int LEN_W = 12);
  import scrambler_pkg::*;

  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic [SCR_W-1:0] seed_in;
  logic             abort;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             scr_reset;
  logic [SCR_W-1:0] scr_seed;
  logic             scr_enable;
  logic             bit_out;
  logic             tail_flag;
  logic             busy;
  logic             done;
  logic             underrun;

  modport master (
    output start, frame_len, seed_in, abort, byte_in, byte_valid,
    input  byte_ready, scr_reset, scr_seed, scr_enable, bit_out, tail_flag,
           busy, done, underrun
  );

  modport slave (
    input  start, frame_len, seed_in, abort, byte_in, byte_valid,
    output byte_ready, scr_reset, scr_seed, scr_enable, bit_out, tail_flag,
           busy, done, underrun
  );

endinterface

// File: rtl/scrambler_frame_ctrl_byte_serializer.sv
// Payload byte serializer: 8-bit shift register emitting bit 0 first, with a bit counter.
module byte_serializer (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic       i_advance,
  input  logic [7:0] i_byte,
  output logic       o_bit,
  output logic       o_full,
  output logic       o_last
);

  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_full;

  always_ff @(posedge clock) begin
    if (!reset || i_clear) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_full    <= 1'b0;
    end else if (i_load) begin
      // Loading while empty and advancing means bit 0 went straight out from i_byte.
      if (!r_full && i_advance) begin
        r_shift   <= {1'b0, i_byte[7:1]};
        r_bit_cnt <= 3'd1;
      end else begin
        r_shift   <= i_byte;
        r_bit_cnt <= 3'd0;
      end
      r_full <= 1'b1;
    end else if (i_advance && r_full) begin
      if (r_bit_cnt == 3'd7) begin
        r_full    <= 1'b0;
        r_bit_cnt <= 3'd0;
      end else begin
        r_shift   <= r_shift >> 1;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  assign o_bit  = r_full ? r_shift[0] : i_byte[0];
  assign o_full = r_full;
  assign o_last = (r_bit_cnt == 3'd7);

endmodule

// File: rtl/scrambler_frame_ctrl.sv
// Sequences one data field (seed load, SERVICE, payload, TAIL) into the 7-bit scrambler.
// Build option SCR_SEED_ROTATE_EN: use an internal rotating seed instead of seed_in.
module scrambler_frame_ctrl
  import scrambler_pkg::*;
#(
  parameter int LEN_W     = 12,
  parameter int TAIL_BITS = 6
) (
  input logic                 clock,
  input logic                 reset,
  scrambler_frame_ctrl_if.slave bus
);

  state_t           r_state;
  logic [LEN_W-1:0] r_bytes_left;
  logic [3:0]       r_svc_cnt;
  logic [2:0]       r_tail_cnt;
  logic [SCR_W-1:0] r_seed;

  logic             w_ser_bit;
  logic             w_ser_full;
  logic             w_ser_last;
  logic             w_bytes_avail;
  logic             w_svc_last;
  logic             w_tail_last;
  logic             w_byte_ready;
  logic             w_take;
  logic             w_pay_bit;
  logic             w_payload_end;
  logic [SCR_W-1:0] w_frame_seed;

  assign w_bytes_avail = (r_bytes_left != '0);
  assign w_svc_last    = (r_svc_cnt == 4'(SERVICE_BITS - 1));
  assign w_tail_last   = (r_tail_cnt == 3'(TAIL_BITS - 1));

  always_comb begin
    w_byte_ready = 1'b0;
    if (!bus.abort) begin
      case (r_state)
        ST_SERVICE: w_byte_ready = w_svc_last && w_bytes_avail;
        ST_PAYLOAD: w_byte_ready = (!w_ser_full || w_ser_last) && w_bytes_avail;
        default:    w_byte_ready = 1'b0;
      endcase
    end
  end

  assign w_take        = w_byte_ready && bus.byte_valid;
  assign w_pay_bit     = (r_state == ST_PAYLOAD) && (w_ser_full || w_take);
  assign w_payload_end = (r_state == ST_PAYLOAD) && w_ser_full && w_ser_last && !w_bytes_avail;

`ifdef SCR_SEED_ROTATE_EN
  logic [SCR_W-1:0] r_rot_seed;

  // Only frames that actually reach DONE move the seed on; aborts leave it alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rot_seed <= 7'h01;
    end else if (r_state == ST_TAIL && w_tail_last && !bus.abort) begin
      r_rot_seed <= next_rot_seed(r_rot_seed);
    end
  end

  assign w_frame_seed = r_rot_seed;
`else
  assign w_frame_seed = fix_seed(bus.seed_in);
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_bytes_left <= '0;
      r_svc_cnt    <= '0;
      r_tail_cnt   <= '0;
      r_seed       <= DEFAULT_SEED;
    end else if (r_state != ST_IDLE && bus.abort) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state      <= ST_SEED;
            r_bytes_left <= bus.frame_len;
            r_seed       <= w_frame_seed;
            r_svc_cnt    <= '0;
            r_tail_cnt   <= '0;
          end
        end
        ST_SEED: r_state <= ST_SERVICE;
        ST_SERVICE: begin
          r_svc_cnt <= r_svc_cnt + 4'd1;
          if (w_svc_last) r_state <= w_bytes_avail ? ST_PAYLOAD : ST_TAIL;
        end
        ST_PAYLOAD: begin
          if (w_payload_end) r_state <= ST_TAIL;
        end
        ST_TAIL: begin
          r_tail_cnt <= r_tail_cnt + 3'd1;
          if (w_tail_last) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_take && w_bytes_avail) r_bytes_left <= r_bytes_left - 1'b1;
    end
  end

  byte_serializer u_ser (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (r_state == ST_IDLE),
    .i_load    (w_take),
    .i_advance (w_pay_bit),
    .i_byte    (bus.byte_in),
    .o_bit     (w_ser_bit),
    .o_full    (w_ser_full),
    .o_last    (w_ser_last)
  );

  assign bus.byte_ready = w_byte_ready;
  assign bus.scr_reset  = (r_state == ST_SEED);
  assign bus.scr_seed   = r_seed;
  assign bus.scr_enable = (r_state == ST_SERVICE) || (r_state == ST_TAIL) || w_pay_bit;
  assign bus.bit_out    = w_pay_bit && w_ser_bit;
  assign bus.tail_flag  = (r_state == ST_TAIL);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.underrun   = (r_state == ST_PAYLOAD) && !w_pay_bit;

endmodule
